// File: rtl/lcd_power_seq_if.sv
// rtl/lcd_power_seq_if.sv - strap, frame, backlight and sequencing signals of the LCD power sequencer
interface lcd_power_seq_if;
    logic [2:0]  id_pins;
    logic        lcd_vs;
    logic [7:0]  bl_level;
    logic        reseq;
    logic        rgb_oe;
    logic [15:0] ID_lcd;
    logic        id_valid;
    logic        drv_rst_n;
    logic        lcd_rst_n;
    logic        lcd_bl;
    logic        ready;

    modport slave (
        input  id_pins, lcd_vs, bl_level, reseq,
        output rgb_oe, ID_lcd, id_valid, drv_rst_n, lcd_rst_n, lcd_bl, ready
    );

    modport master (
        output id_pins, lcd_vs, bl_level, reseq,
        input  rgb_oe, ID_lcd, id_valid, drv_rst_n, lcd_rst_n, lcd_bl, ready
    );
endinterface

// File: rtl/lcd_power_seq.sv
// rtl/lcd_power_seq.sv - LCD power-up sequencer: strap ID read, panel reset, driver release, backlight
// Optional PWM backlight when LCD_BL_PWM_EN is defined; otherwise the backlight is a plain on/off.
module lcd_power_seq #(
    parameter int ID_SETTLE_CYC   = 16,
    parameter int ID_STABLE_CNT   = 4,
    parameter int ID_MAX_SAMPLES  = 255,
    parameter int RST_LOW_CYC     = 10000,
    parameter int RST_WAIT_CYC    = 10000,
    parameter int BL_DELAY_FRAMES = 2
) (
    input  logic           lcd_clk,
    input  logic           sys_rst_n,
    lcd_power_seq_if.slave bus
);
    typedef enum logic [2:0] {
        ID_SETTLE, ID_SAMPLE, PANEL_RST, PANEL_WAIT, RUN_DARK, RUN
    } state_t;

    localparam logic [23:0] SETTLE_LD = 24'(ID_SETTLE_CYC - 1);
    localparam logic [23:0] SAMPLE_LD = 24'(ID_MAX_SAMPLES - 1);
    localparam logic [23:0] LOW_LD    = 24'(RST_LOW_CYC - 1);
    localparam logic [23:0] WAIT_LD   = 24'(RST_WAIT_CYC - 1);
    localparam logic [23:0] BL_LD     = 24'(BL_DELAY_FRAMES - 1);
    localparam logic [7:0]  STABLE_C  = 8'(ID_STABLE_CNT);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [7:0]  match_q, match_d;
    logic [2:0]  id_prev_q, id_prev_d;
    logic        vs_q, vs_d;
    logic        tick_q, tick_d;
    logic [15:0] id_lcd_q, id_lcd_d;
    logic        id_valid_q, id_valid_d;
    logic        rgb_oe_q, rgb_oe_d;
    logic        drv_rst_n_q, drv_rst_n_d;
    logic        lcd_rst_n_q, lcd_rst_n_d;
    logic        lcd_bl_q, lcd_bl_d;
    logic        ready_q, ready_d;

`ifdef LCD_BL_PWM_EN
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [7:0]  bl_q, bl_d;
`else
    logic [7:0]  unused_bl_level;
    assign unused_bl_level = bus.bl_level;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        match_d    = match_q;
        id_prev_d  = id_prev_q;
        id_lcd_d   = id_lcd_q;
        id_valid_d = id_valid_q;
        vs_d       = bus.lcd_vs;
        tick_d     = bus.lcd_vs & ~vs_q;

        case (state_q)
            ID_SETTLE: begin
                if (cnt_q == 24'd0) begin
                    state_d = ID_SAMPLE;
                    cnt_d   = SAMPLE_LD;
                    match_d = 8'd0;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            ID_SAMPLE: begin
                // match_q == 0 marks the first sample, which has no predecessor
                id_prev_d = bus.id_pins;
                if (match_q != 8'd0 && bus.id_pins == id_prev_q) begin
                    match_d = match_q + 8'd1;
                end else begin
                    match_d = 8'd1;
                end
                if (match_d == STABLE_C) begin
                    state_d = PANEL_RST;
                    cnt_d   = LOW_LD;
                    case (bus.id_pins)
                        3'b000, 3'b001, 3'b010, 3'b101: begin
                            id_lcd_d   = {13'b0, bus.id_pins};
                            id_valid_d = 1'b1;
                        end
                        default: begin
                            id_lcd_d   = 16'd0;
                            id_valid_d = 1'b0;
                        end
                    endcase
                end else if (cnt_q == 24'd0) begin
                    state_d    = PANEL_RST;
                    cnt_d      = LOW_LD;
                    id_lcd_d   = 16'd0;
                    id_valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            PANEL_RST: begin
                if (cnt_q == 24'd0) begin
                    state_d = PANEL_WAIT;
                    cnt_d   = WAIT_LD;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            PANEL_WAIT: begin
                if (cnt_q == 24'd0) begin
                    state_d = RUN_DARK;
                    cnt_d   = BL_LD;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            RUN_DARK: begin
                if (tick_q) begin
                    if (cnt_q == 24'd0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 24'd1;
                    end
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = ID_SETTLE;
                cnt_d   = SETTLE_LD;
            end
        endcase

        // Restart keeps the previously published ID until a new one is accepted
        if (bus.reseq) begin
            state_d    = ID_SETTLE;
            cnt_d      = SETTLE_LD;
            match_d    = 8'd0;
            id_lcd_d   = id_lcd_q;
            id_valid_d = id_valid_q;
        end

        rgb_oe_d    = (state_d != ID_SETTLE) && (state_d != ID_SAMPLE);
        lcd_rst_n_d = (state_d == PANEL_WAIT) || (state_d == RUN_DARK) || (state_d == RUN);
        drv_rst_n_d = (state_d == RUN_DARK) || (state_d == RUN);
        ready_d     = (state_d == RUN);

`ifdef LCD_BL_PWM_EN
        pwm_cnt_d = 8'd0;
        bl_d      = 8'd0;
        if (state_d == RUN) begin
            if (state_q != RUN) begin
                bl_d = bus.bl_level;
            end else begin
                pwm_cnt_d = pwm_cnt_q + 8'd1;
                bl_d      = tick_q ? bus.bl_level : bl_q;
            end
        end
        lcd_bl_d = (state_d == RUN) && ((bl_d == 8'hFF) || (pwm_cnt_d < bl_d));
`else
        lcd_bl_d = (state_d == RUN);
`endif
    end

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ID_SETTLE;
            cnt_q       <= SETTLE_LD;
            match_q     <= 8'd0;
            id_prev_q   <= 3'd0;
            vs_q        <= 1'b0;
            tick_q      <= 1'b0;
            id_lcd_q    <= 16'd0;
            id_valid_q  <= 1'b0;
            rgb_oe_q    <= 1'b0;
            drv_rst_n_q <= 1'b0;
            lcd_rst_n_q <= 1'b0;
            lcd_bl_q    <= 1'b0;
            ready_q     <= 1'b0;
`ifdef LCD_BL_PWM_EN
            pwm_cnt_q   <= 8'd0;
            bl_q        <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            match_q     <= match_d;
            id_prev_q   <= id_prev_d;
            vs_q        <= vs_d;
            tick_q      <= tick_d;
            id_lcd_q    <= id_lcd_d;
            id_valid_q  <= id_valid_d;
            rgb_oe_q    <= rgb_oe_d;
            drv_rst_n_q <= drv_rst_n_d;
            lcd_rst_n_q <= lcd_rst_n_d;
            lcd_bl_q    <= lcd_bl_d;
            ready_q     <= ready_d;
`ifdef LCD_BL_PWM_EN
            pwm_cnt_q   <= pwm_cnt_d;
            bl_q        <= bl_d;
`endif
        end
    end

    assign bus.rgb_oe    = rgb_oe_q;
    assign bus.ID_lcd    = id_lcd_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.drv_rst_n = drv_rst_n_q;
    assign bus.lcd_rst_n = lcd_rst_n_q;
    assign bus.lcd_bl    = lcd_bl_q;
    assign bus.ready     = ready_q;
endmodule

// File: doc/lcd_power_seq.md
# lcd_power_seq

Power-up sequencer and configuration controller for the RGB LCD timing driver. After reset it reads the panel-ID strap pins while the RGB bus is tri-stated, then publishes the decoded `ID_lcd`. It then pulses the panel reset, releases the timing driver from reset and turns on the backlight after a programmable number of frames. In run mode it drives an 8-bit PWM backlight whose level changes only at frame boundaries.

## Interface
Parameters:
- `ID_SETTLE_CYC`, default 16: cycles the RGB bus is tri-stated before the first ID sample.
- `ID_STABLE_CNT`, default 4: number of consecutive identical samples that accept an ID.
- `ID_MAX_SAMPLES`, default 255: sample cycles allowed before the ID read times out.
- `RST_LOW_CYC`, default 10000: cycles `lcd_rst_n` is held low.
- `RST_WAIT_CYC`, default 10000: cycles after `lcd_rst_n` rises before the driver is enabled.
- `BL_DELAY_FRAMES`, default 2: frame ticks between driver enable and backlight on (range 1..255).

Ports:
- `lcd_clk` in 1: pixel clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `id_pins` in 3: strap inputs {M2,M1,M0}, sampled from RGB bits.
- `lcd_vs` in 1: vsync from the timing driver.
- `bl_level` in 8: requested backlight duty.
- `reseq` in 1: single-cycle pulse that restarts the whole sequence.
- `rgb_oe` out 1: 1 = RGB bus driven by the FPGA; 0 = tri-stated for ID read.
- `ID_lcd` out 16: decoded panel ID for the timing driver.
- `id_valid` out 1: 1 = `ID_lcd` came from a stable, known strap value.
- `drv_rst_n` out 1: active-low reset for the timing driver.
- `lcd_rst_n` out 1: active-low panel reset.
- `lcd_bl` out 1: backlight enable / PWM.
- `ready` out 1: sequence complete, backlight on.

## Operation
- States: `ID_SETTLE`, `ID_SAMPLE`, `PANEL_RST`, `PANEL_WAIT`, `RUN_DARK`, `RUN`.
- One shared 24-bit down-counter serves all states.
  - On entry it is loaded with param-1.
  - Each state lasts exactly param cycles; all cycle parameters are ≤ 2^24-1.
- `ID_SETTLE`:
  - `rgb_oe`=0.
  - After `ID_SETTLE_CYC` cycles, go to `ID_SAMPLE`.
- `ID_SAMPLE`:
  - `rgb_oe`=0; `id_pins` is sampled every cycle.
  - A match counter increments when the sample equals the previous sample and reloads to 1 otherwise.
  - When the count reaches `ID_STABLE_CNT`, the sample is decoded:
    - 000 → 0
    - 001 → 1
    - 010 → 2
    - 101 → 5
  - A known code gives `ID_lcd`={13'b0,code} and `id_valid`=1.
  - An unknown code gives `ID_lcd`=0 and `id_valid`=0.
  - After `ID_MAX_SAMPLES` samples without stability, `ID_lcd`=0 and `id_valid`=0.
  - Either outcome goes to `PANEL_RST`; `rgb_oe` becomes 1 on that transition.
- `PANEL_RST`: `lcd_rst_n`=0 for `RST_LOW_CYC` cycles.
- `PANEL_WAIT`: `lcd_rst_n`=1 for `RST_WAIT_CYC` cycles.
- `RUN_DARK`:
  - `drv_rst_n`=1.
  - Frame tick = rising edge of `lcd_vs`, detected against a one-cycle registered copy.
  - After `BL_DELAY_FRAMES` ticks, go to `RUN`.
- `RUN`:
  - `ready`=1; backlight on.
  - `bl_level` is captured into `bl_q` on each frame tick only.
- `reseq` in any state:
  - Next state is `ID_SETTLE`.
  - All outputs return to their reset values except `ID_lcd` and `id_valid`, which hold until the new ID is accepted.
- `ID_lcd` is stable whenever `drv_rst_n`=1.

## Timing
- Reset values: `rgb_oe`=0, `ID_lcd`=0, `id_valid`=0, `drv_rst_n`=0, `lcd_rst_n`=0, `lcd_bl`=0, `ready`=0, `bl_q`=0, state `ID_SETTLE`.
- All outputs are registered; each changes on the clock edge that enters the state.
- Frame tick latency: `lcd_vs` rise → tick is seen one cycle later.
- In `RUN_DARK`, the tick numbered `BL_DELAY_FRAMES` moves to `RUN` on the next edge.
- PWM:
  - 8-bit free-running counter `pwm_cnt`, cleared outside `RUN`.
  - `lcd_bl` = (`pwm_cnt` < `bl_q`), except `bl_q`=255 gives constant 1.
  - `bl_q`=0 gives constant 0.
  - Period is 256 cycles.
- `bl_q` on entry to `RUN` is loaded with `bl_level` directly; it updates only on ticks thereafter.
- `reseq` coinciding with a state transition: `reseq` wins.
- `reseq` coinciding with a frame tick: the tick is ignored.
- Asynchronous reset mid-sequence returns everything to reset values immediately; no partial state is retained.

## Configuration
- `LCD_BL_PWM_EN` defined: PWM backlight as above.
- `LCD_BL_PWM_EN` undefined:
  - `lcd_bl` = 1 in `RUN`, 0 elsewhere.
  - `bl_level` is ignored.
  - `pwm_cnt` and `bl_q` are not built.

## Test plan
All directed scenarios use `ID_SETTLE_CYC`=4, `ID_STABLE_CNT`=3, `ID_MAX_SAMPLES`=8, `RST_LOW_CYC`=10, `RST_WAIT_CYC`=5, `BL_DELAY_FRAMES`=2, and a model `lcd_vs` with a 100-cycle period.

- Strap 001 constant → `ID_lcd`=1, `id_valid`=1; `rgb_oe` rises at cycle 4+3; `lcd_rst_n` is low for exactly 10 cycles; `drv_rst_n` rises 5 cycles later.
- Strap 101 → `ID_lcd`=5; strap 011 → `ID_lcd`=0, `id_valid`=0; sequence continues in both cases.
- Strap toggling every cycle → timeout after 8 samples; `ID_lcd`=0, `id_valid`=0; goes to `PANEL_RST`.
- In `RUN_DARK`: `lcd_bl`=0 until the 2nd `lcd_vs` rise + 2 cycles; then `ready`=1.
- PWM build: `bl_level`=64 → 64 high cycles per 256; change to 192 mid-frame → duty changes only after the next `lcd_vs` rise; `bl_level`=255 → `lcd_bl` constant 1.
- `reseq` pulse in `RUN` → next cycle `ready`=0, `lcd_bl`=0, `drv_rst_n`=0, `rgb_oe`=0; `ID_lcd` holds its old value until re-accepted. Assert `sys_rst_n` low mid-`PANEL_RST` → all outputs go to reset values asynchronously.
